// File: rtl/tlb_op_unit.sv
// Sequencer for the LoongArch TLB management instructions (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB).
// Runs IDLE -> EXEC -> DONE per request. TLB drive is combinational in EXEC; the CSR update is registered into DONE.
module tlb_op_unit #(
    parameter int unsigned TLBNUM = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [2:0]                op_type,
    input  logic [4:0]                inv_op,
    input  logic [9:0]                inv_asid,
    input  logic [18:0]               inv_vppn,
    input  logic [$clog2(TLBNUM)-1:0] csr_index,
    input  logic [5:0]                csr_ps,
    input  logic                      csr_ne,
    input  logic [18:0]               csr_vppn,
    input  logic [9:0]                csr_asid,
    input  logic [31:0]               csr_elo0,
    input  logic [31:0]               csr_elo1,
    input  logic                      csr_refill,
    output logic                      s1_own,
    output logic [18:0]               s1_vppn,
    output logic [9:0]                s1_asid,
    output logic                      s1_va_bit12,
    input  logic                      s1_found,
    input  logic [$clog2(TLBNUM)-1:0] s1_index,
    output logic                      invtlb_valid,
    output logic [4:0]                invtlb_op,
    output logic                      we,
    output logic [$clog2(TLBNUM)-1:0] w_index,
    output logic [36:0]               w_hi,
    output logic [25:0]               w_lo0,
    output logic [25:0]               w_lo1,
    output logic [$clog2(TLBNUM)-1:0] r_index,
    input  logic [36:0]               r_hi,
    input  logic [25:0]               r_lo0,
    input  logic [25:0]               r_lo1,
    output logic                      upd_valid,
    output logic                      upd_idx_en,
    output logic [$clog2(TLBNUM)-1:0] upd_index,
    output logic                      upd_ne,
    output logic [5:0]                upd_ps,
    output logic                      upd_ehi_en,
    output logic [18:0]               upd_vppn,
    output logic                      upd_elo_en,
    output logic [31:0]               upd_elo0,
    output logic [31:0]               upd_elo1,
    output logic                      upd_asid_en,
    output logic [9:0]                upd_asid
);
    localparam int unsigned IW = $clog2(TLBNUM);
    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      req_op;
    logic [4:0]      req_inv_op;
    logic [9:0]      req_inv_asid;
    logic [18:0]     req_inv_vppn;
    logic [IW-1:0]   req_index;
    logic [5:0]      req_ps;
    logic            req_ne;
    logic [18:0]     req_vppn;
    logic [9:0]      req_asid;
    logic [31:0]     req_elo0;
    logic [31:0]     req_elo1;
    logic            req_refill;
    logic [IW-1:0]   fill_ptr;
    logic            accept;
    logic            unused_elo_bits;

    // CSR ELO layout -> TLB lo bus layout and back
    function automatic logic [25:0] elo_to_lo(input logic [31:0] elo);
        return {elo[27:8], elo[3:2], elo[5:4], elo[1], elo[0]};
    endfunction

    function automatic logic [31:0] lo_to_elo(input logic [25:0] lo, input logic g);
        return {4'b0, lo[25:6], 1'b0, g, lo[3:2], lo[5:4], lo[1], lo[0]};
    endfunction

    assign accept          = op_valid && (state == S_IDLE);
    assign unused_elo_bits = ^{req_elo0[31:28], req_elo0[7], req_elo1[31:28], req_elo1[7]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Request snapshot; later csr_* changes do not affect an accepted op
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_op       <= '0;
            req_inv_op   <= '0;
            req_inv_asid <= '0;
            req_inv_vppn <= '0;
            req_index    <= '0;
            req_ps       <= '0;
            req_ne       <= 1'b0;
            req_vppn     <= '0;
            req_asid     <= '0;
            req_elo0     <= '0;
            req_elo1     <= '0;
            req_refill   <= 1'b0;
        end else if (accept) begin
            req_op       <= op_type;
            req_inv_op   <= inv_op;
            req_inv_asid <= inv_asid;
            req_inv_vppn <= inv_vppn;
            req_index    <= csr_index;
            req_ps       <= csr_ps;
            req_ne       <= csr_ne;
            req_vppn     <= csr_vppn;
            req_asid     <= csr_asid;
            req_elo0     <= csr_elo0;
            req_elo1     <= csr_elo1;
            req_refill   <= csr_refill;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_ptr <= '0;
        end else if (state == S_DONE && req_op == OP_FILL) begin
            fill_ptr <= (fill_ptr == IW'(TLBNUM - 1)) ? '0 : fill_ptr + IW'(1);
        end
    end

    // Next state and TLB drive
    always_comb begin
        state_nxt    = state;
        op_ready     = 1'b0;
        s1_own       = 1'b0;
        s1_vppn      = '0;
        s1_asid      = '0;
        s1_va_bit12  = 1'b0;
        invtlb_valid = 1'b0;
        invtlb_op    = '0;
        we           = 1'b0;
        w_index      = '0;
        w_hi         = '0;
        w_lo0        = '0;
        w_lo1        = '0;
        r_index      = '0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_DONE;
                case (req_op)
                    OP_SRCH: begin
                        s1_own  = 1'b1;
                        s1_vppn = req_vppn;
                        s1_asid = req_asid;
                    end
                    OP_RD: r_index = req_index;
                    OP_WR, OP_FILL: begin
                        we      = 1'b1;
                        w_index = (req_op == OP_FILL) ? fill_ptr : req_index;
                        w_hi    = {req_refill | ~req_ne, req_vppn, req_ps, req_asid,
                                   req_elo0[6] & req_elo1[6]};
                        w_lo0   = elo_to_lo(req_elo0);
                        w_lo1   = elo_to_lo(req_elo1);
                    end
                    OP_INV: begin
                        s1_own  = 1'b1;
                        s1_vppn = req_inv_vppn;
                        s1_asid = req_inv_asid;
                        if (req_inv_op <= 5'd6) begin
                            invtlb_valid = 1'b1;
                            invtlb_op    = req_inv_op;
                        end
                    end
                    default: ;
                endcase
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    logic            nxt_valid, nxt_idx_en, nxt_ne, nxt_ehi_en, nxt_elo_en, nxt_asid_en;
    logic [IW-1:0]   nxt_index;
    logic [5:0]      nxt_ps;
    logic [18:0]     nxt_vppn;
    logic [31:0]     nxt_elo0, nxt_elo1;
    logic [9:0]      nxt_asid;

    // CSR update computed from EXEC-cycle TLB results; zero outside EXEC so DONE is a single pulse
    always_comb begin
        nxt_valid   = 1'b0;
        nxt_idx_en  = 1'b0;
        nxt_index   = '0;
        nxt_ne      = 1'b0;
        nxt_ps      = '0;
        nxt_ehi_en  = 1'b0;
        nxt_vppn    = '0;
        nxt_elo_en  = 1'b0;
        nxt_elo0    = '0;
        nxt_elo1    = '0;
        nxt_asid_en = 1'b0;
        nxt_asid    = '0;
        if (state == S_EXEC) begin
            nxt_valid = 1'b1;
            if (req_op == OP_SRCH) begin
                nxt_idx_en = 1'b1;
                nxt_ne     = ~s1_found;
                nxt_index  = s1_found ? s1_index : req_index;
            end else if (req_op == OP_RD) begin
                nxt_idx_en  = 1'b1;
                nxt_ehi_en  = 1'b1;
                nxt_elo_en  = 1'b1;
                nxt_asid_en = 1'b1;
                nxt_index   = req_index;
                if (r_hi[36]) begin
                    nxt_ps   = r_hi[16:11];
                    nxt_vppn = r_hi[35:17];
                    nxt_asid = r_hi[10:1];
                    nxt_elo0 = lo_to_elo(r_lo0, r_hi[0]);
                    nxt_elo1 = lo_to_elo(r_lo1, r_hi[0]);
                end else begin
                    nxt_ne = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            upd_valid   <= 1'b0;
            upd_idx_en  <= 1'b0;
            upd_index   <= '0;
            upd_ne      <= 1'b0;
            upd_ps      <= '0;
            upd_ehi_en  <= 1'b0;
            upd_vppn    <= '0;
            upd_elo_en  <= 1'b0;
            upd_elo0    <= '0;
            upd_elo1    <= '0;
            upd_asid_en <= 1'b0;
            upd_asid    <= '0;
        end else begin
            upd_valid   <= nxt_valid;
            upd_idx_en  <= nxt_idx_en;
            upd_index   <= nxt_index;
            upd_ne      <= nxt_ne;
            upd_ps      <= nxt_ps;
            upd_ehi_en  <= nxt_ehi_en;
            upd_vppn    <= nxt_vppn;
            upd_elo_en  <= nxt_elo_en;
            upd_elo0    <= nxt_elo0;
            upd_elo1    <= nxt_elo1;
            upd_asid_en <= nxt_asid_en;
            upd_asid    <= nxt_asid;
        end
    end
endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed bench for tlb_op_unit: each task drives one scenario and compares against hand-computed values.
module tb_tlb_op_unit;
    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid, op_ready;
    logic [2:0]  op_type;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vppn;
    logic [3:0]  csr_index;
    logic [5:0]  csr_ps;
    logic        csr_ne;
    logic [18:0] csr_vppn;
    logic [9:0]  csr_asid;
    logic [31:0] csr_elo0, csr_elo1;
    logic        csr_refill;
    logic        s1_own, s1_va_bit12, s1_found;
    logic [18:0] s1_vppn;
    logic [9:0]  s1_asid;
    logic [3:0]  s1_index;
    logic        invtlb_valid;
    logic [4:0]  invtlb_op;
    logic        we;
    logic [3:0]  w_index, r_index;
    logic [36:0] w_hi, r_hi;
    logic [25:0] w_lo0, w_lo1, r_lo0, r_lo1;
    logic        upd_valid, upd_idx_en, upd_ne, upd_ehi_en, upd_elo_en, upd_asid_en;
    logic [3:0]  upd_index;
    logic [5:0]  upd_ps;
    logic [18:0] upd_vppn;
    logic [31:0] upd_elo0, upd_elo1;
    logic [9:0]  upd_asid;

    int n_cmp = 0;
    int n_err = 0;

    tlb_op_unit #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .csr_index(csr_index), .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_vppn(csr_vppn),
        .csr_asid(csr_asid), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_refill(csr_refill),
        .s1_own(s1_own), .s1_vppn(s1_vppn), .s1_asid(s1_asid), .s1_va_bit12(s1_va_bit12),
        .s1_found(s1_found), .s1_index(s1_index),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .we(we), .w_index(w_index), .w_hi(w_hi), .w_lo0(w_lo0), .w_lo1(w_lo1),
        .r_index(r_index), .r_hi(r_hi), .r_lo0(r_lo0), .r_lo1(r_lo1),
        .upd_valid(upd_valid), .upd_idx_en(upd_idx_en), .upd_index(upd_index), .upd_ne(upd_ne),
        .upd_ps(upd_ps), .upd_ehi_en(upd_ehi_en), .upd_vppn(upd_vppn), .upd_elo_en(upd_elo_en),
        .upd_elo0(upd_elo0), .upd_elo1(upd_elo1), .upd_asid_en(upd_asid_en), .upd_asid(upd_asid)
    );

    always #5 clk = ~clk;

    // Present a request at the negedge; returns 1ns into the EXEC cycle
    task automatic issue(input logic [2:0] t);
        @(negedge clk);
        op_type  = t;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", op_ready); end
        n_cmp++; if ({we, s1_own, invtlb_valid, s1_va_bit12} !== 4'b0) begin n_err++; $display("FAIL rst_drive: got %b want 0000", {we, s1_own, invtlb_valid, s1_va_bit12}); end
        n_cmp++; if ({w_hi, w_lo0, w_index, r_index, s1_vppn} !== '0) begin n_err++; $display("FAIL rst_bus: got nonzero want 0"); end
        n_cmp++; if ({upd_valid, upd_idx_en, upd_ehi_en, upd_elo_en, upd_asid_en, upd_ne} !== 6'b0) begin n_err++; $display("FAIL rst_upd: got %b want 000000", {upd_valid, upd_idx_en, upd_ehi_en, upd_elo_en, upd_asid_en, upd_ne}); end
    endtask

    task automatic test_fill3();
        for (int i = 0; i < 3; i++) begin
            issue(3'd3);
            n_cmp++; if (we !== 1'b1 || w_index !== 4'(i)) begin n_err++; $display("FAIL fill3_idx%0d: got we=%b idx=%0d want we=1 idx=%0d", i, we, w_index, i); end
            n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL fill3_busy: got %b want 0", op_ready); end
            next_cyc();
            n_cmp++; if (upd_valid !== 1'b1 || we !== 1'b0) begin n_err++; $display("FAIL fill3_done: got v=%b we=%b want v=1 we=0", upd_valid, we); end
            next_cyc();
            n_cmp++; if (op_ready !== 1'b1 || upd_valid !== 1'b0) begin n_err++; $display("FAIL fill3_idle: got rdy=%b v=%b want 1 0", op_ready, upd_valid); end
        end
    endtask

    task automatic test_wr();
        csr_index = 4'd5; csr_ne = 1'b0; csr_refill = 1'b0;
        csr_vppn = 19'h5A5A5; csr_ps = 6'd12; csr_asid = 10'h155;
        csr_elo0 = 32'h0123455F; csr_elo1 = 32'h00000040;
        issue(3'd2);
        csr_index = 4'd7; csr_elo0 = 32'h0;
        n_cmp++; if (we !== 1'b1 || w_index !== 4'd5) begin n_err++; $display("FAIL wr_we_idx: got we=%b idx=%0d want 1 5", we, w_index); end
        n_cmp++; if (w_hi !== {1'b1, 19'h5A5A5, 6'd12, 10'h155, 1'b1}) begin n_err++; $display("FAIL wr_hi: got %h want %h", w_hi, {1'b1, 19'h5A5A5, 6'd12, 10'h155, 1'b1}); end
        n_cmp++; if (w_lo0 !== {20'h12345, 2'b11, 2'b01, 1'b1, 1'b1}) begin n_err++; $display("FAIL wr_lo0: got %h want %h", w_lo0, {20'h12345, 2'b11, 2'b01, 1'b1, 1'b1}); end
        n_cmp++; if (w_lo1 !== 26'h0) begin n_err++; $display("FAIL wr_lo1: got %h want 0", w_lo1); end
        next_cyc();
        n_cmp++; if (we !== 1'b0 || upd_valid !== 1'b1) begin n_err++; $display("FAIL wr_done: got we=%b v=%b want 0 1", we, upd_valid); end
        n_cmp++; if ({upd_idx_en, upd_ehi_en, upd_elo_en, upd_asid_en} !== 4'b0) begin n_err++; $display("FAIL wr_en: got %b want 0000", {upd_idx_en, upd_ehi_en, upd_elo_en, upd_asid_en}); end
        next_cyc();
    endtask

    task automatic test_srch();
        csr_vppn = 19'h0ABCD; csr_asid = 10'h21; csr_index = 4'd4;
        issue(3'd0);
        s1_found = 1'b1; s1_index = 4'd9;
        n_cmp++; if ({s1_own, s1_va_bit12} !== 2'b10 || s1_vppn !== 19'h0ABCD || s1_asid !== 10'h21) begin n_err++; $display("FAIL srch_drive: got own=%b b12=%b vppn=%h asid=%h want 1 0 0abcd 021", s1_own, s1_va_bit12, s1_vppn, s1_asid); end
        next_cyc();
        n_cmp++; if ({upd_valid, upd_idx_en, upd_ne, upd_ehi_en} !== 4'b1100 || upd_index !== 4'd9) begin n_err++; $display("FAIL srch_hit: got v/en/ne/ehi=%b idx=%0d want 1100 9", {upd_valid, upd_idx_en, upd_ne, upd_ehi_en}, upd_index); end
        next_cyc();
        issue(3'd0);
        s1_found = 1'b0; s1_index = 4'd9;
        next_cyc();
        n_cmp++; if ({upd_valid, upd_idx_en, upd_ne} !== 3'b111 || upd_index !== 4'd4) begin n_err++; $display("FAIL srch_miss: got v/en/ne=%b idx=%0d want 111 4", {upd_valid, upd_idx_en, upd_ne}, upd_index); end
        next_cyc();
    endtask

    task automatic test_rd();
        csr_index = 4'd11;
        issue(3'd1);
        r_hi = {1'b0, 19'h7FFFF, 6'd12, 10'h3FF, 1'b1}; r_lo0 = 26'h3FFFFFF; r_lo1 = 26'h155;
        n_cmp++; if (r_index !== 4'd11) begin n_err++; $display("FAIL rd_index: got %0d want 11", r_index); end
        next_cyc();
        n_cmp++; if ({upd_idx_en, upd_ehi_en, upd_elo_en, upd_asid_en, upd_ne} !== 5'b11111) begin n_err++; $display("FAIL rd_inv_en: got %b want 11111", {upd_idx_en, upd_ehi_en, upd_elo_en, upd_asid_en, upd_ne}); end
        n_cmp++; if ({upd_asid, upd_elo0, upd_elo1, upd_vppn, upd_ps} !== '0) begin n_err++; $display("FAIL rd_inv_val: got asid=%h elo0=%h want 0 0", upd_asid, upd_elo0); end
        next_cyc();
        issue(3'd1);
        r_hi  = {1'b1, 19'h12345, 6'd22, 10'h2AB, 1'b1};
        r_lo0 = {20'hABCDE, 2'b10, 2'b01, 1'b1, 1'b1};
        r_lo1 = {20'h00F0F, 2'b00, 2'b11, 1'b0, 1'b1};
        next_cyc();
        n_cmp++; if (upd_ne !== 1'b0 || upd_ps !== 6'd22 || upd_vppn !== 19'h12345 || upd_asid !== 10'h2AB) begin n_err++; $display("FAIL rd_hi: got ne=%b ps=%0d vppn=%h asid=%h want 0 22 12345 2ab", upd_ne, upd_ps, upd_vppn, upd_asid); end
        n_cmp++; if (upd_elo0 !== 32'h0ABCDE5B || upd_elo1 !== 32'h000F0F71) begin n_err++; $display("FAIL rd_elo: got %h %h want 0abcde5b 000f0f71", upd_elo0, upd_elo1); end
        next_cyc();
        r_hi = '0; r_lo0 = '0; r_lo1 = '0;
    endtask

    task automatic test_inv();
        inv_op = 5'd5; inv_asid = 10'h3; inv_vppn = 19'h1ABCD;
        issue(3'd4);
        inv_op = 5'd0;
        n_cmp++; if (invtlb_valid !== 1'b1 || invtlb_op !== 5'd5) begin n_err++; $display("FAIL inv_ctl: got v=%b op=%0d want 1 5", invtlb_valid, invtlb_op); end
        n_cmp++; if (s1_own !== 1'b1 || s1_asid !== 10'h3 || s1_vppn !== 19'h1ABCD) begin n_err++; $display("FAIL inv_s1: got own=%b asid=%h vppn=%h want 1 003 1abcd", s1_own, s1_asid, s1_vppn); end
        next_cyc();
        n_cmp++; if (upd_valid !== 1'b1 || invtlb_valid !== 1'b0 || upd_idx_en !== 1'b0) begin n_err++; $display("FAIL inv_done: got v=%b inv=%b en=%b want 1 0 0", upd_valid, invtlb_valid, upd_idx_en); end
        next_cyc();
        inv_op = 5'd9;
        issue(3'd4);
        n_cmp++; if (invtlb_valid !== 1'b0) begin n_err++; $display("FAIL inv_bad_op: got %b want 0", invtlb_valid); end
        next_cyc();
        n_cmp++; if (upd_valid !== 1'b1) begin n_err++; $display("FAIL inv_bad_done: got %b want 1", upd_valid); end
        next_cyc();
    endtask

    task automatic test_noop();
        issue(3'd6);
        n_cmp++; if ({we, s1_own, invtlb_valid} !== 3'b0 || op_ready !== 1'b0) begin n_err++; $display("FAIL noop_exec: got %b rdy=%b want 000 0", {we, s1_own, invtlb_valid}, op_ready); end
        next_cyc();
        n_cmp++; if (upd_valid !== 1'b1 || {upd_idx_en, upd_elo_en} !== 2'b0) begin n_err++; $display("FAIL noop_done: got v=%b en=%b want 1 00", upd_valid, {upd_idx_en, upd_elo_en}); end
        next_cyc();
    endtask

    // op_valid held high through EXEC/DONE must not start a second op
    task automatic test_back_to_back();
        issue(3'd3);
        op_valid = 1'b1; op_type = 3'd2;
        n_cmp++; if (w_index !== 4'd3) begin n_err++; $display("FAIL b2b_fill: got %0d want 3", w_index); end
        next_cyc();
        op_valid = 1'b0;
        next_cyc();
        n_cmp++; if (we !== 1'b0 || op_ready !== 1'b1 || upd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_ignored: got we=%b rdy=%b v=%b want 0 1 0", we, op_ready, upd_valid); end
    endtask

    task automatic test_reset_mid_exec();
        issue(3'd3);
        n_cmp++; if (we !== 1'b1 || w_index !== 4'd4) begin n_err++; $display("FAIL mid_pre: got we=%b idx=%0d want 1 4", we, w_index); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (we !== 1'b0 || w_index !== 4'd0) begin n_err++; $display("FAIL mid_we_drop: got we=%b idx=%0d want 0 0", we, w_index); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_cmp++; if (op_ready !== 1'b1 || upd_valid !== 1'b0) begin n_err++; $display("FAIL mid_after: got rdy=%b v=%b want 1 0", op_ready, upd_valid); end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < 17; i++) begin
            issue(3'd3);
            n_cmp++; if (we !== 1'b1 || w_index !== 4'(i % 16)) begin n_err++; $display("FAIL wrap_idx%0d: got we=%b idx=%0d want 1 %0d", i, we, w_index, i % 16); end
            next_cyc();
            next_cyc();
        end
    endtask

    initial begin
        resetn = 1'b0; op_valid = 1'b0; op_type = '0;
        inv_op = '0; inv_asid = '0; inv_vppn = '0;
        csr_index = '0; csr_ps = '0; csr_ne = 1'b0; csr_vppn = '0; csr_asid = '0;
        csr_elo0 = '0; csr_elo1 = '0; csr_refill = 1'b0;
        s1_found = 1'b0; s1_index = '0; r_hi = '0; r_lo0 = '0; r_lo1 = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        test_reset();
        test_fill3();
        test_wr();
        test_srch();
        test_rd();
        test_inv();
        test_noop();
        test_back_to_back();
        test_reset_mid_exec();
        test_fill_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
